mult_seq: RTL and testbench

Sequential signed 32×32 shift-and-add multiplier for the processor execute stage. It sits beside the combinational shifter and ALU on the same operand bus. The pipeline stalls on it for multiply instructions and releases when it signals ready. It produces the low 32 bits of the signed product and an overflow flag consumed by the writeback/exception logic.

---
 rtl/mult_defs.sv | 22 ++
 rtl/mult_seq_if.sv | 25 ++
 rtl/add64.sv | 14 +
 rtl/mult_seq.sv | 106 ++++++++++
 tb/tb_mult_seq.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/mult_defs.sv
// Shared types and constants for the sequential multiplier.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package mult_defs;

    localparam int WIDTH      = 32;
    localparam int MULT_ITERS = 32;
    localparam int CNT_W      = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FIX  = 2'd2
    } state_t;

    // Magnitude of a two's complement word; the most negative value maps to
    // itself, which is the correct magnitude when read as unsigned.
    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? ((~v) + WIDTH'(1)) : v;
    endfunction

endpackage

// File: rtl/mult_seq_if.sv
// Operand/result bundle between the execute stage and the multiplier.
// Latency: n/a (wires only).
// Backpressure: none; the pipeline stalls on busy until data_resultRDY.
interface mult_seq_if;
    import mult_defs::*;

    logic             ctrl_MULT;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    modport master (
        output ctrl_MULT, data_operandA, data_operandB,
        input  data_result, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  ctrl_MULT, data_operandA, data_operandB,
        output data_result, data_exception, data_resultRDY, busy
    );

endinterface

// File: rtl/add64.sv
// 64-bit adder shared by the accumulate step and the final negation.
// Latency: combinational.
// Backpressure: none.
module add64 (
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [63:0] sum
);

    // Carry-out is dropped: magnitudes never exceed 64 bits, and the
    // negation of zero must wrap back to zero.
    assign sum = a + b;

endmodule

// File: rtl/mult_seq.sv
// Signed 32x32 shift-and-add multiplier, low word plus signed-overflow flag.
// Latency: 33 cycles from accepted start edge to the data_resultRDY edge.
// Backpressure: starts are accepted only in IDLE; pulses while busy are dropped.
module mult_seq
    import mult_defs::*;
(
    input  logic       clock,
    input  logic       reset,
    mult_seq_if.slave  bus
);

    state_t           state, state_nxt;
    logic [63:0]      mcand;
    logic [63:0]      acc;
    logic [WIDTH-1:0] magb;
    logic             neg;
    logic [CNT_W-1:0] count;

    logic [63:0]      add_a, add_b, add_sum;
    logic [63:0]      p64;
    logic             ovf;

    logic [WIDTH-1:0] result_q;
    logic             exc_q;
    logic             rdy_q;

    add64 u_add (
        .a   (add_a),
        .b   (add_b),
        .sum (add_sum)
    );

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and adder operand selection: accumulate in BUSY, negate in FIX.
    always_comb begin
        state_nxt = state;
        add_a     = acc;
        add_b     = mcand;
        case (state)
            IDLE: if (bus.ctrl_MULT) state_nxt = BUSY;
            BUSY: if (count == CNT_W'(MULT_ITERS - 1)) state_nxt = FIX;
            FIX: begin
                state_nxt = IDLE;
                add_a     = ~acc;
                add_b     = 64'd1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Signed product and overflow: the upper 33 bits must all match the sign.
    always_comb begin
        p64 = neg ? add_sum : acc;
        ovf = !((&p64[63:31]) || !(|p64[63:31]));
    end

    // Operand capture, iteration datapath and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mcand    <= '0;
            acc      <= '0;
            magb     <= '0;
            neg      <= 1'b0;
            count    <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            rdy_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.ctrl_MULT) begin
                        mcand <= {32'd0, abs_val(bus.data_operandA)};
                        magb  <= abs_val(bus.data_operandB);
                        neg   <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
                        acc   <= '0;
                        count <= '0;
                    end
                end
                BUSY: begin
                    if (magb[0]) acc <= add_sum;
                    mcand <= mcand << 1;
                    magb  <= magb >> 1;
                    count <= count + CNT_W'(1);
                end
                FIX: begin
                    result_q <= p64[31:0];
                    exc_q    <= ovf;
                    rdy_q    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.data_result    = result_q;
    assign bus.data_exception = exc_q;
    assign bus.data_resultRDY = rdy_q;
    assign bus.busy           = (state != IDLE);

endmodule

// File: tb/tb_mult_seq.sv
// Directed-vector and random bench for the sequential multiplier.
// Latency: expects completion pulse 33 cycles after each accepted start.
// Backpressure: exercises dropped starts while busy and back-to-back starts.
module tb_mult_seq;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_fail;

    mult_seq_if bus();

    mult_seq dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        exc;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One full operation; lat counts falling edges after the start edge until rdy.
    task automatic do_mult(input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] res, output logic exc,
                           output int lat, output int busy_cnt);
        @(negedge clock);
        bus.ctrl_MULT     = 1'b1;
        bus.data_operandA = a;
        bus.data_operandB = b;
        @(negedge clock);
        bus.ctrl_MULT     = 1'b0;
        bus.data_operandA = $urandom;
        bus.data_operandB = $urandom;
        lat      = 0;
        busy_cnt = bus.busy ? 1 : 0;
        while (!bus.data_resultRDY && lat < 100) begin
            @(negedge clock);
            lat++;
            if (bus.busy) busy_cnt++;
        end
        res = bus.data_result;
        exc = bus.data_exception;
    endtask

    initial begin
        logic [31:0] res;
        logic        exc;
        int          lat;
        int          bcnt;
        int          extra_rdy;
        logic [31:0] ra, rb;
        longint      pa, pb, prod;
        logic [63:0] pv;

        n_checks = 0;
        n_fail   = 0;

        vecs[0]  = '{32'd3,          32'd5,          32'h0000000F, 1'b0};
        vecs[1]  = '{32'hFFFFFFF9,   32'd6,          32'hFFFFFFD6, 1'b0};
        vecs[2]  = '{32'h7FFFFFFF,   32'd2,          32'hFFFFFFFE, 1'b1};
        vecs[3]  = '{32'h80000000,   32'hFFFFFFFF,   32'h80000000, 1'b1};
        vecs[4]  = '{32'h80000000,   32'd1,          32'h80000000, 1'b0};
        vecs[5]  = '{32'd0,          32'h80000000,   32'h00000000, 1'b0};
        vecs[6]  = '{32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000001, 1'b0};
        vecs[7]  = '{32'h00010000,   32'h00010000,   32'h00000000, 1'b1};
        vecs[8]  = '{32'hFFFFFFFF,   32'h80000000,   32'h80000000, 1'b1};
        vecs[9]  = '{32'd46341,      32'd46341,      32'h80001219, 1'b1};
        vecs[10] = '{32'd46340,      32'd46340,      32'h7FFEA810, 1'b0};
        vecs[11] = '{32'h0000FFFF,   32'h0000FFFF,   32'hFFFE0001, 1'b1};

        bus.ctrl_MULT     = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        reset             = 1'b0;
        #12;
        check("reset_result", 64'(bus.data_result), 64'd0);
        check("reset_exc",    64'(bus.data_exception), 64'd0);
        check("reset_rdy",    64'(bus.data_resultRDY), 64'd0);
        check("reset_busy",   64'(bus.busy), 64'd0);
        @(negedge clock);
        reset = 1'b1;

        // Directed table.
        for (int i = 0; i < 12; i++) begin
            do_mult(vecs[i].a, vecs[i].b, res, exc, lat, bcnt);
            check($sformatf("vec%0d_result", i), 64'(res), 64'(vecs[i].res));
            check($sformatf("vec%0d_exc", i),    64'(exc), 64'(vecs[i].exc));
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd33);
            check($sformatf("vec%0d_busy_cycles", i), 64'(bcnt), 64'd33);
        end

        // Dropped starts while busy, then a start in the rdy cycle.
        @(negedge clock);
        bus.ctrl_MULT     = 1'b1;
        bus.data_operandA = 32'd4;
        bus.data_operandB = 32'd4;
        @(negedge clock);
        extra_rdy = 0;
        for (int cyc = 1; cyc <= 70; cyc++) begin
            bus.ctrl_MULT     = (cyc == 5 || cyc == 33 || cyc == 34);
            bus.data_operandA = 32'd9;
            bus.data_operandB = 32'd9;
            @(negedge clock);
            if (cyc == 33) begin
                check("b2b_first_rdy", 64'(bus.data_resultRDY), 64'd1);
                check("b2b_first_result", 64'(bus.data_result), 64'd16);
            end else if (cyc == 67) begin
                check("b2b_second_rdy", 64'(bus.data_resultRDY), 64'd1);
                check("b2b_second_result", 64'(bus.data_result), 64'd81);
            end else if (bus.data_resultRDY) begin
                extra_rdy++;
            end
            if (cyc == 50) check("b2b_result_hold", 64'(bus.data_result), 64'd16);
        end
        bus.ctrl_MULT = 1'b0;
        check("b2b_no_extra_rdy", 64'(extra_rdy), 64'd0);

        // Reset in the middle of an operation.
        @(negedge clock);
        bus.ctrl_MULT     = 1'b1;
        bus.data_operandA = 32'd1000;
        bus.data_operandB = 32'd1000;
        @(negedge clock);
        bus.ctrl_MULT = 1'b0;
        repeat (10) @(negedge clock);
        check("abort_busy_before", 64'(bus.busy), 64'd1);
        reset = 1'b0;
        #1;
        check("abort_result", 64'(bus.data_result), 64'd0);
        check("abort_exc",    64'(bus.data_exception), 64'd0);
        check("abort_rdy",    64'(bus.data_resultRDY), 64'd0);
        check("abort_busy",   64'(bus.busy), 64'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        extra_rdy = 0;
        repeat (50) begin
            @(negedge clock);
            if (bus.data_resultRDY) extra_rdy++;
        end
        check("abort_no_rdy", 64'(extra_rdy), 64'd0);
        do_mult(32'd2, 32'd3, res, exc, lat, bcnt);
        check("after_abort_result",  64'(res), 64'd6);
        check("after_abort_latency", 64'(lat), 64'd33);

        // Random operands against a 64-bit reference.
        for (int k = 0; k < 1000; k++) begin
            ra = $urandom >> $urandom_range(0, 31);
            rb = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) ra = -ra;
            if ($urandom_range(0, 1) == 1) rb = -rb;
            pa   = $signed(ra);
            pb   = $signed(rb);
            prod = pa * pb;
            pv   = prod;
            do_mult(ra, rb, res, exc, lat, bcnt);
            check($sformatf("rand%0d_result a=%h b=%h", k, ra, rb), 64'(res), 64'(pv[31:0]));
            check($sformatf("rand%0d_exc a=%h b=%h", k, ra, rb), 64'(exc),
                  64'(pv[63:31] != {33{pv[31]}}));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
